// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller
// Brief    : Four-source edge/level interrupt controller with a byte-wide IO
//            register window (MASK, MODE, PEND, OVR, SWTRIG).
// Revision : 1.0 - initial release
// ============================================================================
module irq_controller #(
    parameter logic [15:0] BASE_ADDR = 16'h1010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  irq_in,
    input  logic [15:0] dMemIOAddress,
    input  logic [7:0]  dMemIOIn,
    input  logic        dMemIOWriteEn,
    input  logic        dMemIOReadEn,
    output logic [7:0]  dout,
    output logic        interrupt_0,
    output logic        interrupt_1,
    output logic        interrupt_2,
    output logic        interrupt_3,
    input  logic        interrupt_0_clr,
    input  logic        interrupt_1_clr,
    input  logic        interrupt_2_clr,
    input  logic        interrupt_3_clr
);

    localparam logic [2:0] c_OFF_MASK   = 3'd0;
    localparam logic [2:0] c_OFF_MODE   = 3'd1;
    localparam logic [2:0] c_OFF_PEND   = 3'd2;
    localparam logic [2:0] c_OFF_OVR    = 3'd3;
    localparam logic [2:0] c_OFF_SWTRIG = 3'd4;

    logic [3:0] r_s1;
    logic [3:0] r_s2;
    logic [3:0] r_prev;
    logic [3:0] r_mask;
    logic [3:0] r_mode;
    logic [3:0] r_pend;
    logic [3:0] r_ovr;

    logic       w_hit;
    logic [2:0] w_off;
    logic       w_wr;
    logic [3:0] w_event;
    logic [3:0] w_ack;
    logic [3:0] w_set;
    logic [3:0] w_clr;
    logic [3:0] w_ovrSet;
    logic [3:0] w_ovrClr;
    logic [7:0] w_rdData;
    logic       w_unused;

    assign w_hit    = (dMemIOAddress[15:3] == BASE_ADDR[15:3]);
    assign w_off    = dMemIOAddress[2:0];
    assign w_wr     = dMemIOWriteEn & w_hit;
    assign w_unused = &{1'b0, dMemIOIn[7:4]};

    // Edge sources fire on the rising synchronised sample; level sources fire while high.
    assign w_event  = (r_mode & r_s2 & ~r_prev) | (~r_mode & r_s2);
    assign w_ack    = {interrupt_3_clr, interrupt_2_clr, interrupt_1_clr, interrupt_0_clr};

    assign w_set    = w_event | ((w_wr && w_off == c_OFF_SWTRIG) ? dMemIOIn[3:0] : 4'b0000);
    assign w_clr    = w_ack   | ((w_wr && w_off == c_OFF_PEND)   ? dMemIOIn[3:0] : 4'b0000);
    assign w_ovrSet = w_event & r_mode & r_pend & ~w_clr;
    assign w_ovrClr = (w_wr && w_off == c_OFF_OVR) ? dMemIOIn[3:0] : 4'b0000;

    always_comb begin
        w_rdData = 8'h00;
        case (w_off)
            c_OFF_MASK: w_rdData = {4'h0, r_mask};
            c_OFF_MODE: w_rdData = {4'h0, r_mode};
            c_OFF_PEND: w_rdData = {4'h0, r_pend};
            c_OFF_OVR:  w_rdData = {4'h0, r_ovr};
            default:    w_rdData = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1   <= 4'b0000;
            r_s2   <= 4'b0000;
            r_prev <= 4'b0000;
            r_mask <= 4'b0000;
            r_mode <= 4'b0000;
            r_pend <= 4'b0000;
            r_ovr  <= 4'b0000;
            dout   <= 8'h00;
        end else begin
            r_s1   <= irq_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            // Set wins over clear so a coincident new event is never dropped.
            r_pend <= w_set | (r_pend & ~w_clr);
            r_ovr  <= w_ovrSet | (r_ovr & ~w_ovrClr);
            if (w_wr && w_off == c_OFF_MASK) begin
                r_mask <= dMemIOIn[3:0];
            end
            if (w_wr && w_off == c_OFF_MODE) begin
                r_mode <= dMemIOIn[3:0];
            end
            if (dMemIOReadEn) begin
                dout <= w_hit ? w_rdData : 8'h00;
            end
        end
    end

    assign interrupt_0 = r_pend[0] & r_mask[0];
    assign interrupt_1 = r_pend[1] & r_mask[1];
    assign interrupt_2 = r_pend[2] & r_mask[2];
    assign interrupt_3 = r_pend[3] & r_mask[3];

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_controller
// Brief    : Directed and randomized bench for irq_controller against a
//            sample-history reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

    localparam logic [15:0] c_BASE = 16'h1010;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_in;
    logic [15:0] dMemIOAddress;
    logic [7:0]  dMemIOIn;
    logic        dMemIOWriteEn;
    logic        dMemIOReadEn;
    logic [7:0]  dout;
    logic        interrupt_0, interrupt_1, interrupt_2, interrupt_3;
    logic [3:0]  ack;

    int nChecks = 0;
    int nPass   = 0;

    // Reference state: register contents plus the last three irq_in samples.
    bit [3:0] mMask, mMode, mPend, mOvr;
    bit [7:0] mDout;
    bit [3:0] hist [3];

    irq_controller #(.BASE_ADDR(c_BASE)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .irq_in         (irq_in),
        .dMemIOAddress  (dMemIOAddress),
        .dMemIOIn       (dMemIOIn),
        .dMemIOWriteEn  (dMemIOWriteEn),
        .dMemIOReadEn   (dMemIOReadEn),
        .dout           (dout),
        .interrupt_0    (interrupt_0),
        .interrupt_1    (interrupt_1),
        .interrupt_2    (interrupt_2),
        .interrupt_3    (interrupt_3),
        .interrupt_0_clr(ack[0]),
        .interrupt_1_clr(ack[1]),
        .interrupt_2_clr(ack[2]),
        .interrupt_3_clr(ack[3])
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
    endtask

    function automatic bit [3:0] irqVec();
        return {interrupt_3, interrupt_2, interrupt_1, interrupt_0};
    endfunction

    // Advance the model by one clock from the inputs present at the edge.
    task automatic modelStep();
        int  off;
        bit  hit, ev, clr;
        bit  [7:0] rd;
        bit  [3:0] nPend, nOvr;
        if (reset) begin
            mMask = 0; mMode = 0; mPend = 0; mOvr = 0; mDout = 0;
            hist[0] = 0; hist[1] = 0; hist[2] = 0;
            return;
        end
        hit = (dMemIOAddress >= c_BASE) && (dMemIOAddress < c_BASE + 16'd8);
        off = int'(dMemIOAddress) - int'(c_BASE);
        rd = 8'h00;
        if (hit) begin
            if (off == 0) rd = {4'h0, mMask};
            if (off == 1) rd = {4'h0, mMode};
            if (off == 2) rd = {4'h0, mPend};
            if (off == 3) rd = {4'h0, mOvr};
        end
        if (dMemIOReadEn) mDout = rd;
        nPend = mPend;
        nOvr  = mOvr;
        for (int n = 0; n < 4; n++) begin
            ev  = mMode[n] ? (hist[1][n] && !hist[2][n]) : hist[1][n];
            clr = ack[n] || (dMemIOWriteEn && hit && off == 2 && dMemIOIn[n]);
            if (mMode[n] && ev && mPend[n] && !clr) nOvr[n] = 1'b1;
            else if (dMemIOWriteEn && hit && off == 3 && dMemIOIn[n]) nOvr[n] = 1'b0;
            if (ev || (dMemIOWriteEn && hit && off == 4 && dMemIOIn[n])) nPend[n] = 1'b1;
            else if (clr) nPend[n] = 1'b0;
        end
        mPend = nPend;
        mOvr  = nOvr;
        if (dMemIOWriteEn && hit && off == 0) mMask = dMemIOIn[3:0];
        if (dMemIOWriteEn && hit && off == 1) mMode = dMemIOIn[3:0];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = irq_in;
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        checkVal("interrupts", {4'h0, irqVec()}, {4'h0, mPend & mMask});
        checkVal("dout", dout, mDout);
    endtask

    task automatic busWrite(input logic [15:0] addr, input logic [7:0] data);
        dMemIOAddress = addr; dMemIOIn = data; dMemIOWriteEn = 1'b1;
        tick();
        dMemIOWriteEn = 1'b0;
    endtask

    task automatic busRead(input logic [15:0] addr, output logic [7:0] data);
        dMemIOAddress = addr; dMemIOReadEn = 1'b1;
        tick();
        dMemIOReadEn = 1'b0;
        data = dout;
    endtask

    task automatic doReset();
        reset = 1'b1; irq_in = 0; ack = 0;
        tick();
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [7:0] rd;

    initial begin
        reset = 1'b1; irq_in = 0; ack = 0;
        dMemIOAddress = 0; dMemIOIn = 0; dMemIOWriteEn = 0; dMemIOReadEn = 0;
        mMask = 0; mMode = 0; mPend = 0; mOvr = 0; mDout = 0;
        hist[0] = 0; hist[1] = 0; hist[2] = 0;
        tick();
        reset = 1'b0;
        checkVal("reset_dout", dout, 8'h00);
        checkVal("reset_irq", {4'h0, irqVec()}, 8'h00);

        // Edge latency and acknowledge
        busWrite(16'h1010, 8'h01);
        busWrite(16'h1011, 8'h01);
        idle(2);
        irq_in = 4'b0001;
        tick(); checkVal("edge_lat_p0", {7'd0, interrupt_0}, 8'h00);
        tick(); checkVal("edge_lat_p1", {7'd0, interrupt_0}, 8'h00);
        tick(); checkVal("edge_lat_p2", {7'd0, interrupt_0}, 8'h01);
        idle(2);
        irq_in = 0;
        idle(3);
        checkVal("edge_hold", {7'd0, interrupt_0}, 8'h01);
        ack = 4'b0001; tick(); ack = 0;
        checkVal("edge_ack", {7'd0, interrupt_0}, 8'h00);
        busRead(16'h1012, rd); checkVal("edge_pend", rd, 8'h00);

        // Mask gating
        doReset();
        busWrite(16'h1011, 8'h0F);
        irq_in = 4'b0100; idle(4); irq_in = 0; idle(2);
        checkVal("mask_gated", {7'd0, interrupt_2}, 8'h00);
        busRead(16'h1012, rd); checkVal("mask_pend", rd, 8'h04);
        busWrite(16'h1010, 8'h04);
        checkVal("mask_open", {7'd0, interrupt_2}, 8'h01);

        // Set beats clear, then overrun
        doReset();
        busWrite(16'h1011, 8'h02);
        irq_in = 4'b0010; idle(4); irq_in = 0; idle(3);
        irq_in = 4'b0010;
        tick(); tick();
        ack = 4'b0010; tick(); ack = 0;
        busRead(16'h1012, rd); checkVal("sbc_pend", rd, 8'h02);
        busRead(16'h1013, rd); checkVal("sbc_ovr", rd, 8'h00);
        irq_in = 0; idle(3); irq_in = 4'b0010; idle(4);
        busRead(16'h1013, rd); checkVal("ovr_set", rd, 8'h02);
        busWrite(16'h1013, 8'h02);
        busRead(16'h1013, rd); checkVal("ovr_w1c", rd, 8'h00);
        irq_in = 0;

        // Level mode
        doReset();
        busWrite(16'h1010, 8'h08);
        irq_in = 4'b1000; idle(4);
        ack = 4'b1000; tick(); ack = 0;
        checkVal("lvl_hold", {7'd0, interrupt_3}, 8'h01);
        irq_in = 0; idle(3);
        ack = 4'b1000; tick(); ack = 0;
        checkVal("lvl_clr", {7'd0, interrupt_3}, 8'h00);
        idle(3);
        checkVal("lvl_stay", {7'd0, interrupt_3}, 8'h00);
        busRead(16'h1013, rd); checkVal("lvl_ovr", rd, 8'h00);

        // Bus register map
        doReset();
        busWrite(16'h1014, 8'h05);
        busRead(16'h1012, rd); checkVal("swtrig", rd, 8'h05);
        busWrite(16'h1012, 8'h01);
        busRead(16'h1012, rd); checkVal("pend_w1c", rd, 8'h04);
        busRead(16'h1017, rd); checkVal("unmapped", rd, 8'h00);
        busRead(16'h1014, rd); checkVal("swtrig_rd", rd, 8'h00);
        busRead(16'h1012, rd);
        busRead(16'h1020, rd); checkVal("miss", rd, 8'h00);
        busWrite(16'h1010, 8'hFF);
        busRead(16'h1010, rd); checkVal("mask_width", rd, 8'h0F);
        idle(2);
        checkVal("dout_hold", dout, 8'h0F);

        // Reset mid-operation with all lines held
        busWrite(16'h1014, 8'h0F);
        irq_in = 4'hF; idle(3);
        reset = 1'b1; tick(); reset = 1'b0;
        checkVal("rst_irq", {4'h0, irqVec()}, 8'h00);
        busRead(16'h1010, rd); checkVal("rst_mask", rd, 8'h00);
        busWrite(16'h1010, 8'h0F);
        idle(4);
        checkVal("rst_repend", {4'h0, irqVec()}, 8'h0F);
        irq_in = 0;

        // Randomized traffic against the model
        doReset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) irq_in = 4'($urandom);
            ack = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            dMemIOAddress = ($urandom_range(0, 4) == 0) ? 16'($urandom)
                                                         : c_BASE + 16'($urandom_range(0, 7));
            dMemIOIn      = 8'($urandom);
            dMemIOWriteEn = ($urandom_range(0, 3) == 0);
            dMemIOReadEn  = ($urandom_range(0, 1) == 0);
            reset         = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 0; dMemIOWriteEn = 0; dMemIOReadEn = 0; ack = 0;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
